// File: rtl/fetch_queue_if.sv
// Bundle between fetch_queue and its environment: instruction-memory request/response,
// decode handshake and the MEM-stage redirect. master = the queue, slave = the environment.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] incinst;
   logic        inst_ready;
   logic        branch_taken;
   logic [31:0] branch_target;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, incinst,
      input  imem_ready, imem_valid, imem_rdata, inst_ready, branch_taken, branch_target
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, incinst,
      output imem_ready, imem_valid, imem_rdata, inst_ready, branch_taken, branch_target
   );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction prefetch queue between instruction memory and the IF/ID register.
// Define FETCHQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_queue_if.master bus
);
   localparam int unsigned PW      = $clog2(DEPTH);
   localparam int unsigned CW      = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] in_flight_q, in_flight_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] ad_wr_ptr_q, ad_wr_ptr_d, ad_rd_ptr_q, ad_rd_ptr_d;

   logic [31:0] inst_mem    [DEPTH];
   logic [31:0] incinst_mem [DEPTH];
   logic [31:0] pc_mem      [DEPTH];

   logic [CW:0] occupancy;
   logic        req, accept, resp, keep, bypass, push, pop, redirect;
   logic        head_valid;

   always_comb begin
      // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
      redirect  = bus.branch_taken;
      occupancy = {1'b0, count_q} + {1'b0, in_flight_q};
      req       = (state_q != IDLE) && (occupancy < DEPTH_W);
      accept    = req && bus.imem_ready;
      resp      = bus.imem_valid;
      keep      = resp && (drop_cnt_q == '0) && !redirect;
`ifdef FETCHQ_BYPASS_EN
      bypass    = keep && (count_q == '0);
`else
      bypass    = 1'b0;
`endif
      pop       = (count_q != '0) && bus.inst_ready && !redirect;
      push      = keep && !(bypass && bus.inst_ready);

      in_flight_d = in_flight_q + CW'(accept) - CW'(resp);
      ad_wr_ptr_d = ad_wr_ptr_q + PW'(accept);
      ad_rd_ptr_d = ad_rd_ptr_q + PW'(resp);

      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);

      if (redirect) begin
         // Everything still outstanding after this edge, plus a response arriving now, is stale.
         fetch_pc_d = bus.branch_target;
         drop_cnt_d = in_flight_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (accept)                        fetch_pc_d = fetch_pc_q + 32'd4;
         if (resp && (drop_cnt_q != '0))    drop_cnt_d = drop_cnt_q - 1'b1;
      end

      case (state_q)
         IDLE:         state_d = FETCH;
         FETCH, DRAIN: state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
         default:      state_d = IDLE;
      endcase
   end

   always_comb begin
      head_valid     = (count_q != '0);
      bus.imem_req   = req;
      bus.imem_addr  = fetch_pc_q;
      bus.inst_valid = head_valid;
      bus.inst       = head_valid ? inst_mem[rd_ptr_q]    : '0;
      bus.incinst    = head_valid ? incinst_mem[rd_ptr_q] : '0;
`ifdef FETCHQ_BYPASS_EN
      if (bypass) begin
         bus.inst_valid = 1'b1;
         bus.inst       = bus.imem_rdata;
         bus.incinst    = pc_mem[ad_rd_ptr_q] + 32'd4;
      end
`endif
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         count_q     <= '0;
         in_flight_q <= '0;
         drop_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ad_wr_ptr_q <= '0;
         ad_rd_ptr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         count_q     <= count_d;
         in_flight_q <= in_flight_d;
         drop_cnt_q  <= drop_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ad_wr_ptr_q <= ad_wr_ptr_d;
         ad_rd_ptr_q <= ad_rd_ptr_d;
      end
   end

   // NOTE: payload arrays are not reset; count_q and the output gating hide stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr_q]    <= bus.imem_rdata;
         incinst_mem[wr_ptr_q] <= pc_mem[ad_rd_ptr_q] + 32'd4;
      end
      if (accept) pc_mem[ad_wr_ptr_q] <= fetch_pc_q;
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue: an in-order memory model with variable
// latency feeds the DUT, and a queue-level model of accepted/kept words predicts the outputs.
module tb_fetch_queue;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fetch_queue_if bus();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
      bit          stale;
   } req_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] inc;
   } word_t;

   req_t        pend[$];   // accepted requests whose response has not yet returned
   word_t       mq[$];     // words decode should see, head first
   logic [31:0] m_pc;
   bit          m_started;
   int          cyc, seq, dropped, pops;
   int          n_cmp, n_fail;

   int          p_ready, p_iready, lat_min, lat_max;
   bit          hold_resp, br_now;
   logic [31:0] br_tgt;

   bit          chk_en, await_first, got_first;
   logic [31:0] cap_inst, cap_inc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_req();
      return m_started && ((mq.size() + pend.size()) < int'(DEPTH));
   endfunction

   // Applies one clock edge to the model using the inputs the bench is driving.
   task automatic model_step();
      bit   acc, rsp, pop, br;
      req_t r;
      acc = m_req() && bus.imem_ready;
      rsp = bus.imem_valid;
      br  = bus.branch_taken;
      pop = !br && (mq.size() > 0) && bus.inst_ready;
      cyc++;
      if (pop) begin
         void'(mq.pop_front());
         pops++;
      end
      if (rsp) begin
         r = pend.pop_front();
         if (r.stale || br) dropped++;
         else mq.push_back('{inst: r.data, inc: r.addr + 32'd4});
      end
      if (acc) begin
         pend.push_back('{addr:  m_pc,
                          data:  {16'h1000 + seq[15:0], m_pc[15:0]},
                          due:   cyc + int'($urandom_range(lat_max, lat_min)) - 1,
                          stale: 1'b0});
         seq++;
      end
      if (br) begin
         mq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_pc = bus.branch_target;
      end else if (acc) begin
         m_pc = m_pc + 32'd4;
      end
      m_started = 1'b1;
   endtask

   task automatic cycle();
      bus.imem_ready    = int'($urandom_range(99)) < p_ready;
      bus.inst_ready    = int'($urandom_range(99)) < p_iready;
      bus.branch_taken  = br_now;
      bus.branch_target = br_tgt;
      if (!hold_resp && (pend.size() > 0) && (pend[0].due <= cyc)) begin
         bus.imem_valid = 1'b1;
         bus.imem_rdata = pend[0].data;
      end else begin
         bus.imem_valid = 1'b0;
         bus.imem_rdata = $urandom;
      end
      @(posedge clk);
      if (rst_n) model_step();
      br_now = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_imem_req",   {31'd0, bus.imem_req},   32'd0);
      check("rst_imem_addr",  bus.imem_addr,           RESET_PC);
      check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("rst_inst",       bus.inst,                32'd0);
      check("rst_incinst",    bus.incinst,             32'd0);
      pend.delete();
      mq.delete();
      m_pc      = RESET_PC;
      m_started = 1'b0;
      bus.imem_valid    = 1'b0;
      bus.imem_rdata    = '0;
      bus.imem_ready    = 1'b0;
      bus.inst_ready    = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_first(input int budget);
      for (int i = 0; i < budget && !got_first; i++) cycle();
      check("first_word_seen", {31'd0, got_first}, 32'd1);
   endtask

   // Compare process: DUT outputs against the model on every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_req",   {31'd0, bus.imem_req},   {31'd0, m_req()});
         check("imem_addr",  bus.imem_addr,           m_pc);
         check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, mq.size() != 0});
         if (mq.size() != 0) begin
            check("inst",    bus.inst,    mq[0].inst);
            check("incinst", bus.incinst, mq[0].inc);
         end
         if (await_first && bus.inst_valid) begin
            cap_inst    = bus.inst;
            cap_inc     = bus.incinst;
            got_first   = 1'b1;
            await_first = 1'b0;
         end
      end
   end

   initial begin
      int          d0, p0, stale_n;
      bit          cond;
      n_cmp = 0; n_fail = 0; cyc = 0; seq = 0; dropped = 0; pops = 0;
      p_ready = 100; p_iready = 100; lat_min = 2; lat_max = 2;
      hold_resp = 1'b0; br_now = 1'b0; br_tgt = '0;
      chk_en = 1'b0; await_first = 1'b0; got_first = 1'b0;
      m_pc = RESET_PC; m_started = 1'b0;
      bus.imem_valid = 1'b0; bus.imem_rdata = '0; bus.imem_ready = 1'b0;
      bus.inst_ready = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;

      // Streaming with fixed latency: sequential addresses, one word per cycle after fill.
      do_reset();
      chk_en = 1'b1; await_first = 1'b1; got_first = 1'b0;
      repeat (12) cycle();
      check("first_word_seen", {31'd0, got_first}, 32'd1);
      check("first_inst",    cap_inst, 32'h1000_0000);
      check("first_incinst", cap_inc,  32'h0000_0004);
      pops = 0;
      repeat (30) cycle();
      check("throughput", pops, 30);

      // Decode stall: queue plus outstanding requests saturate at DEPTH, then drain cleanly.
      p_iready = 0;
      repeat (10) cycle();
      check("stall_imem_req", {31'd0, bus.imem_req}, 32'd0);
      check("stall_occupancy", mq.size() + pend.size(), DEPTH);
      p_iready = 100;
      repeat (20) cycle();

      // Redirect to 0x100 with exactly three requests outstanding.
      lat_min = 4; lat_max = 4; p_ready = 0;
      repeat (8) cycle();
      p_ready = 100;
      for (int i = 0; i < 20 && pend.size() != 3; i++) cycle();
      check("setup_three_in_flight", pend.size(), 3);
      hold_resp = 1'b1; p_ready = 0; br_now = 1'b1; br_tgt = 32'h0000_0100;
      d0 = dropped; await_first = 1'b1; got_first = 1'b0;
      cycle();
      hold_resp = 1'b0; p_ready = 100;
      wait_first(60);
      check("redir_dropped", dropped - d0, 3);
      check("redir_incinst", cap_inc, 32'h0000_0104);
      check("redir_inst_lo", {16'd0, cap_inst[15:0]}, 32'h0000_0100);

      // Redirect in the same cycle as a response and an accept.
      lat_min = 2; lat_max = 2;
      cond = 1'b0;
      for (int i = 0; i < 50 && !cond; i++) begin
         cycle();
         cond = (pend.size() > 0) && (pend[0].due <= cyc) && m_req();
      end
      check("setup_resp_and_accept", {31'd0, cond}, 32'd1);
      p0 = pend.size();
      br_now = 1'b1; br_tgt = 32'h0000_0180;
      cycle();
      stale_n = 0;
      foreach (pend[i]) if (pend[i].stale) stale_n++;
      check("redir_same_cycle_drop", stale_n, p0);
      check("redir_same_cycle_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("redir_same_cycle_addr", bus.imem_addr, 32'h0000_0180);
      repeat (10) cycle();

      // Second redirect while still draining the first.
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && pend.size() < 2; i++) cycle();
      hold_resp = 1'b1; br_now = 1'b1; br_tgt = 32'h0000_0300;
      cycle();
      hold_resp = 1'b0;
      check("drain_has_stale", {31'd0, (pend.size() > 0) && pend[0].stale}, 32'd1);
      br_now = 1'b1; br_tgt = 32'h0000_0200; await_first = 1'b1; got_first = 1'b0;
      cycle();
      wait_first(60);
      check("redir2_incinst", cap_inc, 32'h0000_0204);

      // Reset in the middle of a busy stream.
      p_ready = 80; p_iready = 80; lat_min = 1; lat_max = 3;
      repeat (15) cycle();
      do_reset();
      lat_min = 2; lat_max = 2; p_ready = 100; p_iready = 100;
      await_first = 1'b1; got_first = 1'b0;
      wait_first(20);
      check("post_reset_incinst", cap_inc, RESET_PC + 32'd4);

      // Random traffic with occasional redirects.
      p_ready = 70; p_iready = 70; lat_min = 1; lat_max = 5;
      for (int i = 0; i < 1500; i++) begin
         br_now = int'($urandom_range(99)) < 4;
         br_tgt = {16'd0, 16'($urandom)} & 32'hFFFF_FFFC;
         cycle();
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
